// File: rtl/rc4_pkg.sv
// Shared RC4 datapath definitions used by init, ksa and prga.
package rc4_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // Byte 0 of both ciphertext and plaintext holds the message length.
  localparam byte_t MSG_LEN_ADDR = 8'd0;

  typedef enum logic [3:0] {
    PRGA_IDLE,
    PRGA_LEN_RD,
    PRGA_LEN_WR,
    PRGA_RD_I,
    PRGA_RD_J,
    PRGA_SWAP_I,
    PRGA_SWAP_J,
    PRGA_RD_PAD,
    PRGA_WR_PT
  } prga_state_t;

endpackage

// File: rtl/prga.sv
// RC4 pseudo-random generation: continues permuting S and decrypts a
// length-prefixed ciphertext into a length-prefixed plaintext memory.
module prga
  import rc4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [BYTE_W-1:0] s_addr,
  input  logic [BYTE_W-1:0] s_rddata,
  output logic [BYTE_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [BYTE_W-1:0] ct_addr,
  input  logic [BYTE_W-1:0] ct_rddata,
  output logic [BYTE_W-1:0] pt_addr,
  output logic [BYTE_W-1:0] pt_wrdata,
  output logic              pt_wren
);

  prga_state_t r_state;
  byte_t       r_i;
  byte_t       r_j;
  byte_t       r_k;
  byte_t       r_len;
  byte_t       r_si;
  byte_t       r_sj;

  byte_t w_i_next;
  byte_t w_j_next;
  byte_t w_pad_idx;

  assign w_i_next  = r_i + 8'd1;
  assign w_j_next  = r_j + s_rddata;
  // Pre-swap si+sj equals the post-swap S[i]+S[j], so no extra reads are needed.
  assign w_pad_idx = r_si + r_sj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PRGA_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_len   <= '0;
      r_si    <= '0;
      r_sj    <= '0;
    end else begin
      case (r_state)
        PRGA_IDLE: begin
          if (en) begin
            r_i     <= '0;
            r_j     <= '0;
            r_state <= PRGA_LEN_RD;
          end
        end
        PRGA_LEN_RD: r_state <= PRGA_LEN_WR;
        PRGA_LEN_WR: begin
          r_len   <= ct_rddata;
          r_k     <= 8'd1;
          r_state <= (ct_rddata == '0) ? PRGA_IDLE : PRGA_RD_I;
        end
        PRGA_RD_I: begin
          r_i     <= w_i_next;
          r_state <= PRGA_RD_J;
        end
        PRGA_RD_J: begin
          r_si    <= s_rddata;
          r_j     <= w_j_next;
          r_state <= PRGA_SWAP_I;
        end
        PRGA_SWAP_I: begin
          r_sj    <= s_rddata;
          r_state <= PRGA_SWAP_J;
        end
        PRGA_SWAP_J: r_state <= PRGA_RD_PAD;
        PRGA_RD_PAD: r_state <= PRGA_WR_PT;
        PRGA_WR_PT: begin
          // Equality stop keeps L=255 from ever needing k=256.
          if (r_k == r_len) begin
            r_state <= PRGA_IDLE;
          end else begin
            r_k     <= r_k + 8'd1;
            r_state <= PRGA_RD_I;
          end
        end
        default: r_state <= PRGA_IDLE;
      endcase
    end
  end

  always_comb begin
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (r_state)
      PRGA_IDLE:   rdy = 1'b1;
      PRGA_LEN_RD: ct_addr = MSG_LEN_ADDR;
      PRGA_LEN_WR: begin
        pt_addr   = MSG_LEN_ADDR;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      PRGA_RD_I:   s_addr = w_i_next;
      PRGA_RD_J:   s_addr = w_j_next;
      PRGA_SWAP_I: begin
        s_addr   = r_i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      PRGA_SWAP_J: begin
        s_addr   = r_j;
        s_wrdata = r_si;
        s_wren   = 1'b1;
      end
      PRGA_RD_PAD: begin
        s_addr  = w_pad_idx;
        ct_addr = r_k;
      end
      PRGA_WR_PT: begin
        pt_addr   = r_k;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Bench for prga: synchronous memory models plus a plain RC4 PRGA reference.
module tb_prga;
  import rc4_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
  logic       s_wren, pt_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] s_img  [256];
  logic [7:0] ct_img [256];
  logic [7:0] pt_mem [256];
  logic [7:0] m_S    [256];
  logic [7:0] m_pt   [256];
  int         pt_hits[256];
  int         pt_wr_total = 0;
  int         s_wr_total = 0;
  logic       s_load = 1'b0;
  logic       pt_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  prga u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_load) s_mem <= s_img;
    else if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_img[ct_addr];
    if (pt_clr) begin
      for (int n = 0; n < 256; n++) pt_hits[n] <= 0;
      pt_wr_total <= 0;
      s_wr_total  <= 0;
    end else begin
      if (pt_wren) begin
        pt_mem[pt_addr]  <= pt_wrdata;
        pt_hits[pt_addr] <= pt_hits[pt_addr] + 1;
        pt_wr_total      <= pt_wr_total + 1;
      end
      if (s_wren) s_wr_total <= s_wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: i=j=0, pt[0]=L, then nb keystream bytes (capped at L).
  task automatic model(input int nb);
    int i, j, L, t;
    i = 0; j = 0;
    L = int'(ct_img[0]);
    m_pt[0] = ct_img[0];
    for (int k = 1; k <= L && k <= nb; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_S[i])) % 256;
      t = int'(m_S[i]);
      m_S[i] = m_S[j];
      m_S[j] = t[7:0];
      m_pt[k] = m_S[(int'(m_S[i]) + int'(m_S[j])) % 256] ^ ct_img[k];
    end
  endtask

  task automatic set_identity();
    for (int n = 0; n < 256; n++) s_img[n] = n[7:0];
  endtask

  task automatic set_random_s();
    logic [7:0] t;
    int r;
    set_identity();
    for (int n = 255; n > 0; n--) begin
      r = int'($urandom_range(0, n));
      t = s_img[n]; s_img[n] = s_img[r]; s_img[r] = t;
    end
  endtask

  task automatic set_random_ct(input int L);
    ct_img[0] = L[7:0];
    for (int n = 1; n < 256; n++) ct_img[n] = 8'($urandom);
  endtask

  task automatic load(input bit with_s);
    @(posedge clk); #1;
    s_load = with_s;
    pt_clr = 1'b1;
    @(posedge clk); #1;
    s_load = 1'b0;
    pt_clr = 1'b0;
    for (int n = 0; n < 256; n++) m_S[n] = s_mem[n];
  endtask

  task automatic run_check(input string tag);
    int L, cyc, bad;
    L = int'(ct_img[0]);
    model(256);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    chk({tag, "_rdy_fall"}, rdy, 0);
    cyc = 1;
    while (!rdy && cyc < 1600) begin
      en = (cyc == 4);  // busy-time request, must be ignored
      @(posedge clk); #1;
      cyc++;
    end
    en = 1'b0;
    chk({tag, "_latency"}, cyc, 3 + 6 * L);
    for (int k = 0; k <= L; k++) chk($sformatf("%s_pt%0d", tag, k), pt_mem[k], m_pt[k]);
    chk({tag, "_pt_writes"}, pt_wr_total, L + 1);
    bad = 0;
    for (int k = 0; k <= L; k++) if (pt_hits[k] != 1) bad++;
    chk({tag, "_pt_once"}, bad, 0);
    chk({tag, "_s_writes"}, s_wr_total, 2 * L);
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== m_S[n]) bad++;
    chk({tag, "_s_final_bad"}, bad, 0);
    chk({tag, "_idle_outs"}, {s_wren, pt_wren, s_addr, ct_addr, pt_addr},  0);
    chk({tag, "_idle_wdata"}, {s_wrdata, pt_wrdata}, 0);
  endtask

  initial begin
    logic [7:0] exp3 [4];
    int cyc, L;

    for (int n = 0; n < 256; n++) begin ct_img[n] = '0; s_img[n] = '0; end

    // Reset held over several edges
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", rdy, 1);
    chk("rst_wren", {s_wren, pt_wren}, 0);
    chk("rst_addr", {s_addr, pt_addr}, 0);
    chk("rst_wrdata", {s_wrdata, pt_wrdata}, 0);
    rst_n = 1'b1;

    // Identity S, ct={3,0,0,0}
    set_identity();
    ct_img[0] = 8'd3; ct_img[1] = 8'd0; ct_img[2] = 8'd0; ct_img[3] = 8'd0;
    load(1);
    run_check("id3");
    exp3[0] = 8'h03; exp3[1] = 8'h02; exp3[2] = 8'h05; exp3[3] = 8'h07;
    for (int k = 0; k < 4; k++) chk($sformatf("id3_const_pt%0d", k), pt_mem[k], exp3[k]);
    chk("id3_S2", s_mem[2], 8'd3);
    chk("id3_S3", s_mem[3], 8'd5);
    chk("id3_S5", s_mem[5], 8'd2);

    // Identity S, ct={1,FF}
    set_identity();
    ct_img[0] = 8'd1; ct_img[1] = 8'hFF;
    load(1);
    run_check("id1");
    chk("id1_const_pt1", pt_mem[1], 8'hFD);

    // L=0 with en held high: completes in 3 cycles, then restarts at once
    set_identity();
    ct_img[0] = 8'd0;
    load(1);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1;
    chk("len0_rdy_fall", rdy, 0);
    cyc = 1;
    while (!rdy && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("len0_latency", cyc, 3);
    chk("len0_pt0", pt_mem[0], 8'd0);
    chk("len0_no_s_wr", s_wr_total, 0);
    @(posedge clk); #1;
    chk("len0_back_to_back", rdy, 0);
    en = 1'b0;
    cyc = 1;
    while (!rdy && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("len0_second_latency", cyc, 3);

    // Random permutations and messages
    for (int t = 0; t < 6; t++) begin
      set_random_s();
      set_random_ct(int'($urandom_range(1, 24)));
      load(1);
      run_check($sformatf("rnd%0d", t));
    end

    // Longest message
    set_identity();
    set_random_ct(255);
    load(1);
    run_check("len255");

    // Async reset during SWAP_I of byte 2, then a fresh run on the partially permuted S
    set_random_s();
    set_random_ct(5);
    load(1);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_pre_wren", s_wren, 1);
    chk("mid_pre_addr", s_addr, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", rdy, 1);
    chk("mid_rst_wren", {s_wren, pt_wren}, 0);
    chk("mid_rst_addr", {s_addr, pt_addr, ct_addr}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    model(1);
    L = int'($urandom_range(1, 8));
    set_random_ct(L);
    load(0);
    run_check("mid_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
